// File: rtl/pe_ctx_sequencer.sv
// Per-PE context sequencer: stores DEPTH 64-bit context words and replays them onto the PE
// register-file control pins. Optional readback port enabled by defining CTX_READBACK_EN.
module pe_ctx_sequencer #(
  parameter int DEPTH   = 16,
  parameter int DEPTH_W = 4,
  parameter int ITER_W  = 16
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [DEPTH_W-1:0] cfg_addr,
  input  logic [63:0]        cfg_data,
`ifdef CTX_READBACK_EN
  input  logic               cfg_rd_en,
  output logic [63:0]        cfg_rd_data,
`endif
  input  logic               start,
  input  logic [DEPTH_W:0]   ctx_len,
  input  logic [ITER_W-1:0]  iter_count,
  input  logic               stall,
  output logic               busy,
  output logic               done,
  output logic [DEPTH_W-1:0] ctx_pc,
  output logic [8:0]         control_in,
  output logic [8:0]         control_out,
  output logic [5:0]         control_reg_1,
  output logic [5:0]         control_reg_2,
  output logic [5:0]         control_put_in,
  output logic [5:0]         control_put_out,
  output logic [5:0]         control_send,
  output logic [3:0]         control_pe2fu_1,
  output logic [3:0]         control_pe2fu_2,
  output logic               write_back,
  output logic               ld,
  output logic               ld_write
);

  // state  | meaning
  // IDLE   | config port open, controls NOP, waiting for start
  // RUN    | replaying mem[pc] once per non-stalled cycle
  // DONE   | one cycle, raises done on the following cycle, back to IDLE
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Only ld set: the register file reads but nothing is written back.
  localparam logic [58:0]        NOP      = 59'h2;
  localparam logic [DEPTH_W:0]   LEN_ONE  = (DEPTH_W+1)'(1);
  localparam logic [ITER_W-1:0]  ITER_ONE = ITER_W'(1);
  localparam logic [DEPTH_W-1:0] PC_ONE   = DEPTH_W'(1);

  state_t             state, state_nx;
  logic [DEPTH_W-1:0] pc;
  logic [ITER_W-1:0]  iter_q;
  logic [DEPTH_W:0]   len_q;
  logic [63:0]        mem [DEPTH];
  logic [63:0]        rd_word;
  logic [58:0]        ctl_q, ctl_d;
  logic [DEPTH_W-1:0] ctx_pc_d;
  logic               busy_d, done_d;
  logic               issue, wrap, last, zero_run;
  logic               unused_rsvd;

  assign cfg_ready   = (state == S_IDLE);
  assign rd_word     = mem[pc];
  assign unused_rsvd = ^rd_word[63:59];
  assign issue       = (state == S_RUN) && !stall;
  assign wrap        = ({1'b0, pc} == (len_q - LEN_ONE));
  assign last        = wrap && (iter_q == ITER_ONE);
  assign zero_run    = (ctx_len == '0) || (iter_count == '0);

  // Context memory is deliberately left out of reset so contents survive RST.
  always_ff @(posedge CLK) begin
    if (cfg_valid && cfg_ready) mem[cfg_addr] <= cfg_data;
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = zero_run ? S_DONE : S_RUN;
      S_RUN:   if (issue && last) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pc     <= '0;
      iter_q <= '0;
      len_q  <= '0;
    end else if (state == S_IDLE) begin
      if (start) begin
        pc     <= '0;
        len_q  <= ctx_len;
        iter_q <= iter_count;
      end
    end else if (issue) begin
      if (wrap) begin
        pc     <= '0;
        iter_q <= iter_q - ITER_ONE;
      end else begin
        pc <= pc + PC_ONE;
      end
    end
  end

  // Outputs are decoded from the current state and registered, so they trail the FSM by a cycle.
  always_comb begin
    ctl_d    = NOP;
    ctx_pc_d = '0;
    busy_d   = (state != S_IDLE);
    done_d   = (state == S_DONE);
    if (state == S_RUN) begin
      if (stall) begin
        ctx_pc_d = ctx_pc;
      end else begin
        ctl_d    = rd_word[58:0];
        ctx_pc_d = pc;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ctl_q  <= NOP;
      ctx_pc <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      ctl_q  <= ctl_d;
      ctx_pc <= ctx_pc_d;
      busy   <= busy_d;
      done   <= done_d;
    end
  end

`ifdef CTX_READBACK_EN
  // Reads the pre-write contents when a write hits the same address in the same cycle.
  always_ff @(posedge CLK) begin
    if (RST)                             cfg_rd_data <= '0;
    else if (state == S_IDLE && cfg_rd_en) cfg_rd_data <= mem[cfg_addr];
  end
`endif

  assign control_in      = ctl_q[58:50];
  assign control_out     = ctl_q[49:41];
  assign control_reg_1   = ctl_q[40:35];
  assign control_reg_2   = ctl_q[34:29];
  assign control_put_in  = ctl_q[28:23];
  assign control_put_out = ctl_q[22:17];
  assign control_send    = ctl_q[16:11];
  assign control_pe2fu_1 = ctl_q[10:7];
  assign control_pe2fu_2 = ctl_q[6:3];
  assign write_back      = ctl_q[2];
  assign ld              = ctl_q[1];
  assign ld_write        = ctl_q[0];

endmodule

// File: tb/tb_pe_ctx_sequencer.sv
// Self-checking bench for pe_ctx_sequencer: scoreboard of expected per-cycle control outputs
// plus directed checks of done/busy timing, reset and config-port behaviour.
module tb_pe_ctx_sequencer;

  localparam logic [58:0] NOP = 59'h2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [3:0]  cfg_addr = '0;
  logic [63:0] cfg_data = '0;
`ifdef CTX_READBACK_EN
  logic        cfg_rd_en = 1'b0;
  logic [63:0] cfg_rd_data;
`endif
  logic        start = 1'b0;
  logic [4:0]  ctx_len = '0;
  logic [15:0] iter_count = '0;
  logic        stall = 1'b0;
  logic        busy, done;
  logic [3:0]  ctx_pc;
  logic [8:0]  control_in, control_out;
  logic [5:0]  control_reg_1, control_reg_2, control_put_in, control_put_out, control_send;
  logic [3:0]  control_pe2fu_1, control_pe2fu_2;
  logic        write_back, ld, ld_write;

  pe_ctx_sequencer dut (
    .CLK(clk), .RST(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
`ifdef CTX_READBACK_EN
    .cfg_rd_en(cfg_rd_en), .cfg_rd_data(cfg_rd_data),
`endif
    .start(start), .ctx_len(ctx_len), .iter_count(iter_count), .stall(stall),
    .busy(busy), .done(done), .ctx_pc(ctx_pc),
    .control_in(control_in), .control_out(control_out),
    .control_reg_1(control_reg_1), .control_reg_2(control_reg_2),
    .control_put_in(control_put_in), .control_put_out(control_put_out),
    .control_send(control_send),
    .control_pe2fu_1(control_pe2fu_1), .control_pe2fu_2(control_pe2fu_2),
    .write_back(write_back), .ld(ld), .ld_write(ld_write)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [58:0] ctl;
    logic        busy;
    logic        done;
    logic [3:0]  pc;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] shadow [16];
  int          tests = 0;
  int          errors = 0;
  int          edge_n = 0;
  int          t0 = 0;
  int          done_edge = -1;
  int          bfall_edge = -1;
  logic        busy_prev = 1'b0;
  logic [58:0] ctl_obs;

  assign ctl_obs = {control_in, control_out, control_reg_1, control_reg_2, control_put_in,
                    control_put_out, control_send, control_pe2fu_1, control_pe2fu_2,
                    write_back, ld, ld_write};

  always @(posedge clk) edge_n++;

  // Scoreboard consumer: one expectation per pushed edge, compared half a cycle later.
  always @(negedge clk) begin
    exp_t e;
    if (done === 1'b1) done_edge = edge_n;
    if (busy_prev === 1'b1 && busy === 1'b0) bfall_edge = edge_n;
    busy_prev = busy;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests++;
      if (ctl_obs !== e.ctl || busy !== e.busy || done !== e.done || ctx_pc !== e.pc) begin
        errors++;
        $display("FAIL scoreboard edge %0d: got ctl=%h busy=%b done=%b pc=%0d, want ctl=%h busy=%b done=%b pc=%0d",
                 edge_n, ctl_obs, busy, done, ctx_pc, e.ctl, e.busy, e.done, e.pc);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cfg_write(input logic [3:0] addr, input logic [63:0] data);
    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_addr  = addr;
    cfg_data  = data;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    shadow[addr] = data;
  endtask

  // Drives one run and pushes the expected output of every edge from start to return-to-idle.
  task automatic run_seq(input int len, input int iter, input int s0, input int sn,
                         input int bw_k, input bit sw, input logic [63:0] sw_data);
    int   ms, pc, it, cpc;
    bit   st, ended;
    exp_t e;
    done_edge  = -1;
    bfall_edge = -1;
    @(negedge clk);
    start      = 1'b1;
    ctx_len    = 5'(len);
    iter_count = 16'(iter);
    if (sw) begin
      cfg_valid = 1'b1;
      cfg_addr  = 4'd0;
      cfg_data  = sw_data;
      shadow[0] = sw_data;
    end
    @(posedge clk); #1;
    start     = 1'b0;
    cfg_valid = 1'b0;
    t0        = edge_n;
    e = '{ctl: NOP, busy: 1'b0, done: 1'b0, pc: 4'd0};
    exp_q.push_back(e);
    ms = (len == 0 || iter == 0) ? 2 : 1;
    pc = 0; it = iter; cpc = 0; ended = 1'b0;
    for (int k = 1; k < 300 && !ended; k++) begin
      @(negedge clk);
      st    = (k >= s0) && (k < s0 + sn);
      stall = st;
      if (k == bw_k) begin
        cfg_valid = 1'b1;
        cfg_addr  = 4'd0;
        cfg_data  = ~shadow[0];
        #1;
        tests++;
        if (cfg_ready !== 1'b0) begin
          errors++;
          $display("FAIL cfg_ready_busy: got %b want 0", cfg_ready);
        end
      end
      @(posedge clk); #1;
      stall     = 1'b0;
      cfg_valid = 1'b0;
      e.busy = (ms != 0);
      e.done = (ms == 2);
      e.ctl  = NOP;
      if (ms == 1) begin
        if (!st) begin
          e.ctl = shadow[pc][58:0];
          cpc   = pc;
          if (pc == len - 1) begin
            pc = 0;
            it--;
            if (it == 0) ms = 2;
          end else begin
            pc++;
          end
        end
        e.pc = 4'(cpc);
      end else if (ms == 2) begin
        e.pc = 4'd0;
        cpc  = 0;
        ms   = 0;
      end else begin
        e.pc  = 4'd0;
        ended = 1'b1;
      end
      exp_q.push_back(e);
    end
    if (!ended) begin
      errors++;
      $display("FAIL run_timeout: run len=%0d iter=%0d never returned to idle", len, iter);
    end
    @(negedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (busy !== 1'b0 || done !== 1'b0 || cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_status: got busy=%b done=%b cfg_ready=%b want 0 0 1", busy, done, cfg_ready);
    end
    tests++;
    if (ld !== 1'b1 || ld_write !== 1'b0 || write_back !== 1'b0) begin
      errors++;
      $display("FAIL reset_ld: got ld=%b ld_write=%b write_back=%b want 1 0 0", ld, ld_write, write_back);
    end
    tests++;
    if (ctl_obs !== NOP || ctx_pc !== 4'd0) begin
      errors++;
      $display("FAIL reset_controls: got ctl=%h pc=%0d want %h 0", ctl_obs, ctx_pc, NOP);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic;
    cfg_write(4'd0, 64'hF800_0000_0000_0000 | (64'd5 << 23) | 64'h4);
    cfg_write(4'd1, (64'd6 << 23) | (64'h1AB << 50) | 64'h1);
    cfg_write(4'd2, (64'd7 << 23) | (64'hA << 7) | (64'h15 << 35));
    run_seq(3, 2, 0, 0, -1, 1'b0, 64'd0);
    tests++;
    if (done_edge - t0 !== 7) begin
      errors++;
      $display("FAIL basic_done_time: got T+%0d want T+7", done_edge - t0);
    end
    tests++;
    if (bfall_edge - t0 !== 8) begin
      errors++;
      $display("FAIL basic_busy_fall: got T+%0d want T+8", bfall_edge - t0);
    end
  endtask

  task automatic test_stall;
    run_seq(3, 2, 2, 2, -1, 1'b0, 64'd0);
    tests++;
    if (done_edge - t0 !== 9) begin
      errors++;
      $display("FAIL stall_done_time: got T+%0d want T+9", done_edge - t0);
    end
    tests++;
    if (bfall_edge - t0 !== 10) begin
      errors++;
      $display("FAIL stall_busy_fall: got T+%0d want T+10", bfall_edge - t0);
    end
  endtask

  task automatic test_zero_and_busy_write;
    run_seq(3, 0, 0, 0, -1, 1'b0, 64'd0);
    tests++;
    if (done_edge - t0 !== 1) begin
      errors++;
      $display("FAIL zero_iter_done: got T+%0d want T+1", done_edge - t0);
    end
    run_seq(0, 2, 0, 0, -1, 1'b0, 64'd0);
    tests++;
    if (done_edge - t0 !== 1) begin
      errors++;
      $display("FAIL zero_len_done: got T+%0d want T+1", done_edge - t0);
    end
    // Write attempted mid-run must be dropped; the rerun checks word 0 is untouched.
    run_seq(3, 2, 0, 0, 3, 1'b0, 64'd0);
    run_seq(3, 1, 0, 0, -1, 1'b0, 64'd0);
  endtask

  task automatic test_reset_mid_run;
    exp_t e;
    done_edge = -1;
    @(negedge clk);
    start = 1'b1; ctx_len = 5'd3; iter_count = 16'd2;
    @(posedge clk); #1;
    start = 1'b0;
    e = '{ctl: NOP, busy: 1'b0, done: 1'b0, pc: 4'd0};
    exp_q.push_back(e);
    @(negedge clk);
    @(posedge clk); #1;
    e = '{ctl: shadow[0][58:0], busy: 1'b1, done: 1'b0, pc: 4'd0};
    exp_q.push_back(e);
    @(negedge clk);
    @(posedge clk); #1;
    e = '{ctl: shadow[1][58:0], busy: 1'b1, done: 1'b0, pc: 4'd1};
    exp_q.push_back(e);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    e = '{ctl: NOP, busy: 1'b0, done: 1'b0, pc: 4'd0};
    exp_q.push_back(e);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    exp_q.push_back(e);
    repeat (4) @(negedge clk);
    #1;
    tests++;
    if (done_edge !== -1) begin
      errors++;
      $display("FAIL reset_mid_run_done: got done at edge %0d want no done", done_edge);
    end
    tests++;
    if (cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_run_idle: got cfg_ready=%b want 1", cfg_ready);
    end
    run_seq(3, 2, 0, 0, -1, 1'b0, 64'd0);
  endtask

  task automatic test_back_to_back;
    run_seq(3, 1, 0, 0, -1, 1'b1, 64'h0000_1234_5678_9ABC);
    run_seq(2, 3, 0, 0, -1, 1'b0, 64'd0);
    tests++;
    if (done_edge - t0 !== 7) begin
      errors++;
      $display("FAIL b2b_done_time: got T+%0d want T+7", done_edge - t0);
    end
  endtask

  task automatic test_full_depth;
    for (int i = 0; i < 16; i++) cfg_write(4'(i), {$urandom, $urandom});
    run_seq(16, 3, 5, 3, -1, 1'b0, 64'd0);
    tests++;
    if (done_edge - t0 !== 52) begin
      errors++;
      $display("FAIL full_depth_done: got T+%0d want T+52", done_edge - t0);
    end
  endtask

`ifdef CTX_READBACK_EN
  task automatic test_readback;
    cfg_write(4'd9, 64'hDEADBEEF_0123ABCD);
    @(negedge clk);
    cfg_rd_en = 1'b1; cfg_addr = 4'd9;
    @(posedge clk); #1;
    cfg_rd_en = 1'b0;
    tests++;
    if (cfg_rd_data !== 64'hDEADBEEF_0123ABCD) begin
      errors++;
      $display("FAIL readback: got %h want %h", cfg_rd_data, 64'hDEADBEEF_0123ABCD);
    end
    @(negedge clk);
    cfg_rd_en = 1'b1; cfg_valid = 1'b1; cfg_addr = 4'd9; cfg_data = 64'h1111_2222_3333_4444;
    @(posedge clk); #1;
    cfg_rd_en = 1'b0; cfg_valid = 1'b0;
    shadow[9] = 64'h1111_2222_3333_4444;
    tests++;
    if (cfg_rd_data !== 64'hDEADBEEF_0123ABCD) begin
      errors++;
      $display("FAIL readback_old: got %h want %h", cfg_rd_data, 64'hDEADBEEF_0123ABCD);
    end
    @(negedge clk);
    cfg_rd_en = 1'b1;
    @(posedge clk); #1;
    cfg_rd_en = 1'b0;
    tests++;
    if (cfg_rd_data !== 64'h1111_2222_3333_4444) begin
      errors++;
      $display("FAIL readback_new: got %h want %h", cfg_rd_data, 64'h1111_2222_3333_4444);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_zero_and_busy_write();
    test_reset_mid_run();
    test_back_to_back();
    test_full_depth();
`ifdef CTX_READBACK_EN
    test_readback();
`endif
    repeat (2) @(negedge clk);
    if (exp_q.size() != 0) begin
      tests++;
      errors++;
      $display("FAIL scoreboard_drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
